// File: rtl/sram_port_arb.sv
// Single-port SRAM arbiter: CPU has default priority, USB wins after STARVE_LIMIT denied cycles.
// Grant is combinational (access completes in grant cycle); CPU read data returns two cycles after grant.
module sram_port_arb #(
  parameter int AW           = 17,
  parameter int DW           = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          cpu_clk,
  input  logic          rstb,
  input  logic          usb_cen,
  input  logic [7:0]    usb_wen,
  input  logic [AW-1:0] usb_a,
  input  logic [DW-1:0] usb_d,
  output logic          usb_ready,
  output logic [DW-1:0] usb_q,
  input  logic          cpu_cen,
  input  logic [7:0]    cpu_wen,
  input  logic [AW-1:0] cpu_a,
  input  logic [DW-1:0] cpu_d,
  output logic          cpu_wait,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_rvalid,
  output logic [15:0]   usb_gnt_cnt,
  input  logic          cnt_clr,
  output logic          mem_cen,
  output logic [7:0]    mem_wen,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_d,
  input  logic [DW-1:0] mem_q
);

  typedef enum logic {NORMAL, USB_PRIO} arb_state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_USB} owner_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  arb_state_t state;
  logic [3:0] starve_cnt;
  owner_t     rd_owner;

  logic usb_req, cpu_req, usb_prio;
  logic usb_gnt, cpu_gnt;

  assign usb_req  = ~usb_cen;
  assign cpu_req  = ~cpu_cen;
  assign usb_prio = (state == USB_PRIO);

  // Reset forces the grant off so the macro never sees a stray access.
  always_comb begin
    usb_gnt = 1'b0;
    cpu_gnt = 1'b0;
    if (rstb) begin
      if (usb_prio && usb_req) usb_gnt = 1'b1;
      else if (cpu_req)        cpu_gnt = 1'b1;
      else if (usb_req)        usb_gnt = 1'b1;
    end
  end

  always_comb begin
    mem_cen = 1'b1;
    mem_wen = 8'hff;
    mem_a   = '0;
    mem_d   = '0;
    if (usb_gnt) begin
      mem_cen = usb_cen;
      mem_wen = usb_wen;
      mem_a   = usb_a;
      mem_d   = usb_d;
    end else if (cpu_gnt) begin
      mem_cen = cpu_cen;
      mem_wen = cpu_wen;
      mem_a   = cpu_a;
      mem_d   = cpu_d;
    end
  end

  assign usb_ready = usb_gnt;
  assign cpu_wait  = cpu_req & ~cpu_gnt & rstb;
  assign usb_q     = mem_q;

  always_ff @(posedge cpu_clk or negedge rstb) begin
    if (!rstb) begin
      state      <= NORMAL;
      starve_cnt <= 4'd0;
    end else begin
      case (state)
        NORMAL: begin
          if (usb_req && !usb_gnt) begin
            if (4'(starve_cnt + 4'd1) == LIMIT) begin
              state      <= USB_PRIO;
              starve_cnt <= 4'd0;
            end else begin
              starve_cnt <= 4'(starve_cnt + 4'd1);
            end
          end else begin
            starve_cnt <= 4'd0;
          end
        end
        USB_PRIO: begin
          // Leaves on the USB grant, or when USB drops its request.
          if (usb_gnt || !usb_req) state <= NORMAL;
          starve_cnt <= 4'd0;
        end
        default: begin
          state      <= NORMAL;
          starve_cnt <= 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge cpu_clk or negedge rstb) begin
    if (!rstb) begin
      rd_owner   <= OWN_NONE;
      cpu_rdata  <= '0;
      cpu_rvalid <= 1'b0;
    end else begin
      if (cpu_gnt && cpu_wen == 8'hff)      rd_owner <= OWN_CPU;
      else if (usb_gnt && usb_wen == 8'hff) rd_owner <= OWN_USB;
      else                                  rd_owner <= OWN_NONE;

      if (rd_owner == OWN_CPU) begin
        cpu_rdata  <= mem_q;
        cpu_rvalid <= 1'b1;
      end else begin
        cpu_rvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge cpu_clk or negedge rstb) begin
    if (!rstb) begin
      usb_gnt_cnt <= 16'd0;
    end else if (cnt_clr) begin
      usb_gnt_cnt <= 16'd0;
    end else if (usb_gnt && usb_gnt_cnt != 16'hffff) begin
      usb_gnt_cnt <= usb_gnt_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_sram_port_arb.sv
// Randomized and directed bench for sram_port_arb with an SRAM environment model
// and a transaction-level reference model checked every cycle on the falling edge.
module tb_sram_port_arb;
  localparam int AW = 17;
  localparam int DW = 64;
  localparam int STARVE_LIMIT = 4;

  logic          cpu_clk = 1'b0;
  logic          rstb;
  logic          usb_cen, cpu_cen, cnt_clr;
  logic [7:0]    usb_wen, cpu_wen;
  logic [AW-1:0] usb_a, cpu_a;
  logic [DW-1:0] usb_d, cpu_d;
  logic          usb_ready, cpu_wait, cpu_rvalid;
  logic [DW-1:0] usb_q, cpu_rdata;
  logic [15:0]   usb_gnt_cnt;
  logic          mem_cen;
  logic [7:0]    mem_wen;
  logic [AW-1:0] mem_a;
  logic [DW-1:0] mem_d;
  logic [DW-1:0] mem_q = '0;

  int n_tests = 0;
  int n_fail  = 0;

  sram_port_arb #(.AW(AW), .DW(DW), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .cpu_clk(cpu_clk), .rstb(rstb),
    .usb_cen(usb_cen), .usb_wen(usb_wen), .usb_a(usb_a), .usb_d(usb_d),
    .usb_ready(usb_ready), .usb_q(usb_q),
    .cpu_cen(cpu_cen), .cpu_wen(cpu_wen), .cpu_a(cpu_a), .cpu_d(cpu_d),
    .cpu_wait(cpu_wait), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .usb_gnt_cnt(usb_gnt_cnt), .cnt_clr(cnt_clr),
    .mem_cen(mem_cen), .mem_wen(mem_wen), .mem_a(mem_a), .mem_d(mem_d), .mem_q(mem_q)
  );

  always #5 cpu_clk = ~cpu_clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d,
                                        input logic [7:0] wen);
    logic [63:0] r;
    r = old;
    for (int b = 0; b < 8; b++)
      if (!wen[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  // SRAM macro environment: one-cycle read latency, byte-masked writes.
  logic [63:0] sram [int];
  always @(posedge cpu_clk) begin
    if (!mem_cen) begin
      if (mem_wen == 8'hff) mem_q <= sram.exists(int'(mem_a)) ? sram[int'(mem_a)] : 64'd0;
      else sram[int'(mem_a)] = merge(sram.exists(int'(mem_a)) ? sram[int'(mem_a)] : 64'd0,
                                     mem_d, mem_wen);
    end
  end

  // Reference model: shadow memory, denied-streak count, read pipelines, grant counter.
  logic [63:0] shadow [int];
  int          streak = 0;
  bit          cr1_v = 0, cr2_v = 0, u1_v = 0;
  logic [63:0] cr1_d = 0, cr2_d = 0, u1_d = 0, last_rd = 0;
  logic [15:0] m_cnt = 0;
  bit          chk_en = 1'b1;

  function automatic logic [63:0] shadow_rd(input logic [AW-1:0] a);
    return shadow.exists(int'(a)) ? shadow[int'(a)] : 64'd0;
  endfunction

  always @(negedge cpu_clk) begin : model
    bit ur, cr, ug, cg;
    logic [7:0] ewen;
    logic [AW-1:0] ea;
    logic [63:0] ed;
    if (chk_en) begin
      ur = !usb_cen;
      cr = !cpu_cen;
      if (!rstb) begin
        chk("rst_usb_ready", usb_ready, 0);
        chk("rst_cpu_wait", cpu_wait, 0);
        chk("rst_mem_cen", mem_cen, 1);
        chk("rst_mem_wen", mem_wen, 8'hff);
        chk("rst_cpu_rvalid", cpu_rvalid, 0);
        chk("rst_cpu_rdata", cpu_rdata, 0);
        chk("rst_cnt", usb_gnt_cnt, 0);
        streak = 0; cr1_v = 0; cr2_v = 0; u1_v = 0; last_rd = 0; m_cnt = 0;
      end else begin
        ug = ur && (streak >= STARVE_LIMIT || !cr);
        cg = cr && !ug;
        chk("usb_ready", usb_ready, ug);
        chk("cpu_wait", cpu_wait, cr && !cg);
        ewen = 8'hff; ea = '0; ed = '0;
        if (ug) begin ewen = usb_wen; ea = usb_a; ed = usb_d; end
        if (cg) begin ewen = cpu_wen; ea = cpu_a; ed = cpu_d; end
        chk("mem_cen", mem_cen, !(ug || cg));
        chk("mem_wen", mem_wen, ewen);
        chk("mem_a", mem_a, ea);
        chk("mem_d", mem_d, ed);
        if (u1_v) chk("usb_q", usb_q, u1_d);
        chk("cpu_rvalid", cpu_rvalid, cr2_v);
        if (cr2_v) last_rd = cr2_d;
        chk("cpu_rdata", cpu_rdata, last_rd);
        chk("usb_gnt_cnt", usb_gnt_cnt, m_cnt);
        if (cnt_clr) m_cnt = 0;
        else if (ug && m_cnt != 16'hffff) m_cnt++;
        cr2_v = cr1_v; cr2_d = cr1_d;
        cr1_v = cg && cpu_wen == 8'hff; cr1_d = shadow_rd(cpu_a);
        u1_v  = ug && usb_wen == 8'hff; u1_d  = shadow_rd(usb_a);
        if (ug && usb_wen != 8'hff) shadow[int'(usb_a)] = merge(shadow_rd(usb_a), usb_d, usb_wen);
        if (cg && cpu_wen != 8'hff) shadow[int'(cpu_a)] = merge(shadow_rd(cpu_a), cpu_d, cpu_wen);
        streak = (ur && !ug) ? streak + 1 : 0;
      end
    end
  end

  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  localparam logic [63:0] D1 = 64'hfeed_beef_1234_5678;
  localparam logic [63:0] D2 = 64'h0123_4567_89ab_cdef;

  initial begin
    bit u_acc, c_acc;
    rstb = 1'b0; cnt_clr = 1'b0;
    usb_cen = 1'b0; usb_wen = 8'hff; usb_a = '0; usb_d = '0;
    cpu_cen = 1'b0; cpu_wen = 8'hff; cpu_a = '0; cpu_d = '0;
    repeat (3) tick();
    #2;
    chk("reset_mem_cen", mem_cen, 1);
    chk("reset_mem_wen", mem_wen, 8'hff);
    chk("reset_cpu_wait", cpu_wait, 0);
    chk("reset_usb_ready", usb_ready, 0);
    chk("reset_cnt", usb_gnt_cnt, 0);
    tick();
    rstb = 1'b1; usb_cen = 1'b1; cpu_cen = 1'b1;
    tick();

    // USB write then read of 0x10
    usb_cen = 1'b0; usb_wen = 8'h00; usb_a = 17'h00010; usb_d = D1;
    #2 chk("usb_wr_ready", usb_ready, 1);
    tick();
    usb_wen = 8'hff;
    #2;
    chk("usb_rd_ready", usb_ready, 1);
    chk("usb_rd_mem_cen", mem_cen, 0);
    chk("usb_rd_mem_a", mem_a, 17'h00010);
    tick();
    usb_cen = 1'b1;
    #2;
    chk("usb_rd_q", usb_q, D1);
    chk("usb_cnt_2", usb_gnt_cnt, 2);
    tick();

    // CPU write then read of 0x100
    cpu_cen = 1'b0; cpu_wen = 8'h00; cpu_a = 17'h00100; cpu_d = D2;
    #2;
    chk("cpu_wr_wait", cpu_wait, 0);
    chk("cpu_wr_mem_wen", mem_wen, 8'h00);
    tick();
    cpu_wen = 8'hff;
    #2 chk("cpu_rd_wait", cpu_wait, 0);
    tick();
    cpu_cen = 1'b1;
    #2 chk("cpu_rvalid_n1", cpu_rvalid, 0);
    tick();
    #2;
    chk("cpu_rvalid_n2", cpu_rvalid, 1);
    chk("cpu_rdata_n2", cpu_rdata, D2);
    tick();
    #2 chk("cpu_rvalid_n3", cpu_rvalid, 0);
    tick();

    // Contention: USB wins every fifth cycle
    cpu_cen = 1'b0; cpu_wen = 8'hff; cpu_a = 17'h00100;
    usb_cen = 1'b0; usb_wen = 8'hff; usb_a = 17'h00010;
    for (int i = 0; i < 10; i++) begin
      #2;
      chk("cont_usb_ready", usb_ready, (i % 5) == 4);
      chk("cont_cpu_wait", cpu_wait, (i % 5) == 4);
      tick();
    end

    // Enter USB priority, then withdraw the USB request before its grant
    for (int i = 0; i < 4; i++) begin
      #2; tick();
    end
    usb_cen = 1'b1;
    #2;
    chk("wd_cpu_wait", cpu_wait, 0);
    chk("wd_mem_a", mem_a, 17'h00100);
    tick();
    usb_cen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #2 chk("wd_usb_ready", usb_ready, i == 4);
      tick();
    end
    usb_cen = 1'b1; cpu_cen = 1'b1;
    tick();

    // Random traffic, each requester holds until granted
    u_acc = 1'b1; c_acc = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (usb_cen || u_acc) begin
        usb_cen = ($urandom_range(0, 3) == 0);
        usb_wen = $urandom_range(0, 1) ? 8'hff : 8'($urandom);
        usb_a   = 17'h00200 + 17'($urandom_range(0, 7));
        usb_d   = {$urandom, $urandom};
      end
      if (cpu_cen || c_acc) begin
        cpu_cen = ($urandom_range(0, 2) == 0);
        cpu_wen = $urandom_range(0, 1) ? 8'hff : 8'($urandom);
        cpu_a   = 17'h00200 + 17'($urandom_range(0, 7));
        cpu_d   = {$urandom, $urandom};
      end
      #2;
      u_acc = usb_ready;
      c_acc = !cpu_cen && !cpu_wait;
      tick();
    end
    usb_cen = 1'b1; cpu_cen = 1'b1;
    tick();

    // Grant counter saturation and clear priority
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    #2 chk("cnt_cleared", usb_gnt_cnt, 0);
    usb_cen = 1'b0; usb_wen = 8'hff; usb_a = 17'h00000;
    repeat (65537) tick();
    #2 chk("cnt_saturated", usb_gnt_cnt, 16'hffff);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0; usb_cen = 1'b1;
    #2 chk("cnt_clr_with_grant", usb_gnt_cnt, 0);
    tick();

    // Reset arriving the cycle after a granted CPU read
    cpu_cen = 1'b0; cpu_wen = 8'hff; cpu_a = 17'h00100;
    tick();
    cpu_cen = 1'b1; rstb = 1'b0;
    #2 chk("rstrd_rvalid_0", cpu_rvalid, 0);
    tick();
    #2 chk("rstrd_rvalid_1", cpu_rvalid, 0);
    tick();
    rstb = 1'b1;
    #2;
    chk("rstrd_mem_cen", mem_cen, 1);
    chk("rstrd_mem_wen", mem_wen, 8'hff);
    chk("rstrd_mem_a", mem_a, 0);
    chk("rstrd_mem_d", mem_d, 0);
    chk("rstrd_cpu_rdata", cpu_rdata, 0);
    chk("rstrd_rvalid_2", cpu_rvalid, 0);
    tick();
    #2 chk("rstrd_rvalid_3", cpu_rvalid, 0);
    tick();
    tick();

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
